// File: rtl/keypad_scan_gen_if.sv
// Keypad scanner pin and event-stream bundle.
//   row      : raw row inputs, active-low (keypad -> scanner)
//   col      : column drive, active-low, one-hot-low (scanner -> keypad)
//   code     : FIFO head, {release_flag, row*COLS+col}
//   valid    : FIFO non-empty
//   ready    : consumer accepts head on valid && ready
//   overflow : one-cycle pulse when an event is dropped on a full FIFO
//   busy     : scanner is not in its free-running scan state
// master = scanner side, slave = keypad/consumer side.
interface keypad_scan_gen_if #(
    parameter int ROWS = 4,
    parameter int COLS = 4
);
    localparam int CODE_W = $clog2(ROWS*COLS);

    logic [ROWS-1:0]   row;
    logic [COLS-1:0]   col;
    logic [CODE_W:0]   code;
    logic              valid;
    logic              ready;
    logic              overflow;
    logic              busy;

    modport master (input row, ready, output col, code, valid, overflow, busy);
    modport slave  (output row, ready, input col, code, valid, overflow, busy);
endinterface

// File: rtl/keypad_scan_gen.sv
// Parametrised keypad matrix scanner with debounce and key-event FIFO.
// Drives an active-low column scan, synchronises the rows, debounces a
// press (and its release), and queues key codes for a valid/ready reader.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : keypad_scan_gen_if.master (row/col pins, code/valid/ready stream,
//          overflow pulse, busy)
// Optional build macro KEYPAD_RELEASE_EVT_EN: also queue release events with
// code[CODE_W] = 1. Without it code[CODE_W] is always 0.
module keypad_scan_gen #(
    parameter int ROWS         = 4,
    parameter int COLS         = 4,
    parameter int SCAN_DIV     = 256,
    parameter int DEBOUNCE_CYC = 1024,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst,
    keypad_scan_gen_if.master bus
);
    localparam int CODE_W = $clog2(ROWS*COLS);
    localparam int CI_W   = $clog2(COLS);
    localparam int DW_W   = $clog2(SCAN_DIV);
    localparam int DB_W   = $clog2(DEBOUNCE_CYC);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);

    localparam logic [ROWS-1:0] ALL_ONES = '1;
    localparam logic [DW_W-1:0] DW_LAST  = DW_W'(SCAN_DIV-1);
    localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYC-1);
    localparam logic [CI_W-1:0] COL_LAST = CI_W'(COLS-1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE_P, HELD, DEBOUNCE_R} state_t;

    // ---------------- row synchroniser ----------------
    logic [ROWS-1:0] row_m, s_row;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_m <= '1;
            s_row <= '1;
        end else begin
            row_m <= bus.row;
            s_row <= row_m;
        end
    end

    // ---------------- scan / debounce FSM ----------------
    state_t          state;
    logic [CI_W-1:0] col_idx, nxt_col;
    logic [COLS-1:0] col_q;
    logic [DW_W-1:0] dwell;
    logic [DB_W-1:0] deb_cnt;
    logic [ROWS-1:0] pat_q;
    logic            busy_q;
    logic [CODE_W-1:0] press_key;
    logic            ev_push;
    logic [CODE_W:0] ev_code;

    assign nxt_col = (col_idx == COL_LAST) ? '0 : col_idx + 1'b1;

    // Lowest-index closed row wins; pat_q and col_idx stay frozen from the
    // press through the release, so the same key code serves both events.
    always_comb begin
        press_key = '0;
        for (int r = ROWS-1; r >= 0; r--)
            if (!pat_q[r]) press_key = CODE_W'(r*COLS) + CODE_W'(col_idx);
    end

    always_comb begin
        ev_push = 1'b0;
        ev_code = {1'b0, press_key};
        case (state)
            DEBOUNCE_P: if (s_row == pat_q && deb_cnt == DB_LAST) ev_push = 1'b1;
`ifdef KEYPAD_RELEASE_EVT_EN
            DEBOUNCE_R: if (s_row == ALL_ONES && deb_cnt == DB_LAST) begin
                ev_push = 1'b1;
                ev_code = {1'b1, press_key};
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= SCAN;
            col_idx <= '0;
            col_q   <= ~COLS'(1);
            dwell   <= '0;
            deb_cnt <= '0;
            pat_q   <= '1;
            busy_q  <= 1'b0;
        end else begin
            case (state)
                SCAN: begin
                    if (dwell == DW_LAST) begin
                        dwell <= '0;
                        if (s_row == ALL_ONES) begin
                            col_idx <= nxt_col;
                            col_q   <= ~(COLS'(1) << nxt_col);
                        end else begin
                            pat_q   <= s_row;
                            deb_cnt <= '0;
                            state   <= DEBOUNCE_P;
                            busy_q  <= 1'b1;
                        end
                    end else begin
                        dwell <= dwell + 1'b1;
                    end
                end
                DEBOUNCE_P: begin
                    if (s_row != pat_q) begin
                        // Bounce: rescan the same column from a fresh dwell.
                        state  <= SCAN;
                        busy_q <= 1'b0;
                        dwell  <= '0;
                    end else if (deb_cnt == DB_LAST) begin
                        state <= HELD;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (s_row == ALL_ONES) begin
                        deb_cnt <= '0;
                        state   <= DEBOUNCE_R;
                    end
                end
                DEBOUNCE_R: begin
                    if (s_row != ALL_ONES) begin
                        state <= HELD;
                    end else if (deb_cnt == DB_LAST) begin
                        state   <= SCAN;
                        busy_q  <= 1'b0;
                        dwell   <= '0;
                        col_idx <= nxt_col;
                        col_q   <= ~(COLS'(1) << nxt_col);
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end

    // ---------------- event FIFO ----------------
    logic [CODE_W:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_inc;
    logic [PTR_W:0]   count, count_nxt, remain;
    logic [CODE_W:0]  code_q;
    logic             valid_q, ovf_q, full, do_pop, do_push;

    assign full      = (count == (PTR_W+1)'(FIFO_DEPTH));
    assign do_pop    = valid_q && bus.ready;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push   = ev_push && (!full || do_pop);
    assign rd_inc    = rd_ptr + 1'b1;
    assign remain    = count - (PTR_W+1)'(do_pop);
    assign count_nxt = remain + (PTR_W+1)'(do_push);

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= ev_code;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            ovf_q   <= ev_push && full && !do_pop;
            count   <= count_nxt;
            valid_q <= (count_nxt != '0);
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_inc;
            // Head register: take the new event directly when it lands in an
            // otherwise empty queue, else follow the read pointer on a pop.
            if (do_push && remain == '0)
                code_q <= ev_code;
            else if (do_pop && remain != '0)
                code_q <= mem[rd_inc];
        end
    end

    assign bus.col      = col_q;
    assign bus.code     = code_q;
    assign bus.valid    = valid_q;
    assign bus.overflow = ovf_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_keypad_scan_gen.sv
// Directed bench for keypad_scan_gen: 4x4 keypad model driven from the
// column outputs, expected key codes queued as keys are pressed and compared
// against the codes the DUT hands over on valid && ready.
module tb_keypad_scan_gen;
    localparam int DEB = 8;

    logic clk, rst;
    logic [15:0] keys;
    logic [3:0]  row_v;

    keypad_scan_gen_if #(.ROWS(4), .COLS(4)) bus ();

    keypad_scan_gen #(
        .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE_CYC(DEB), .FIFO_DEPTH(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Key (r,c) pulls row r low while column c is driven low.
    always_comb begin
        row_v = '1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !bus.col[c]) row_v[r] = 1'b0;
    end
    assign bus.row = row_v;

    // Output monitor: records every handed-over code and overflow pulse.
    logic [4:0] obs [64];
    int n_pop = 0;
    int n_ovf = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.overflow) n_ovf++;
            if (bus.valid && bus.ready) begin
                if (n_pop < 64) obs[n_pop] = bus.code;
                n_pop++;
            end
        end
    end

    int n_assert = 0;
    int n_fail   = 0;
    int rd_idx   = 0;
    logic [4:0] sb [$];

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_assert++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, o, e);
        end
    endtask

    // which: 0 = busy, 1 = valid
    task automatic wait_lvl(input int which, input logic lvl, input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = ((which == 0) ? bus.busy : bus.valid) == lvl;
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    task automatic drain(input string tag);
        logic [4:0] e;
        while (rd_idx < n_pop) begin
            if (sb.size() == 0) begin
                chk({tag, "_unexpected"}, 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                chk(tag, 32'(obs[rd_idx]), 32'(e));
            end
            rd_idx++;
        end
        chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    endtask

    task automatic push_exp(input logic [4:0] c);
        sb.push_back(c);
`ifdef KEYPAD_RELEASE_EVT_EN
        sb.push_back(c | 5'h10);
`endif
    endtask

    task automatic press_release(input logic [15:0] m, input string tag);
        keys = keys | m;
        wait_lvl(0, 1'b1, {tag, "_busy_rise"});
        repeat (DEB + 4) @(posedge clk);
        #1 keys = keys & ~m;
        wait_lvl(0, 1'b0, {tag, "_busy_fall"});
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_col;
        logic [4:0] evl [16];
        int keyl [5];
        int nev, p0, o0;

        rst = 1'b1; bus.ready = 1'b0; keys = '0;
        #2;
        chk("rst_col",   32'(bus.col),      32'hE);
        chk("rst_valid", 32'(bus.valid),    32'd0);
        chk("rst_code",  32'(bus.code),     32'd0);
        chk("rst_ovf",   32'(bus.overflow), 32'd0);
        chk("rst_busy",  32'(bus.busy),     32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Idle scan: each column held 4 clocks, wrapping.
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            exp_col = ~(4'b0001 << ((k / 4) % 4));
            chk("scan_col", 32'(bus.col), 32'(exp_col));
            if (k % 4 == 0) begin
                chk("scan_valid", 32'(bus.valid), 32'd0);
                chk("scan_busy",  32'(bus.busy),  32'd0);
            end
            @(posedge clk); #1;
        end

        // Clean press of key 6 (row1, col2).
        push_exp(5'h06);
        keys[6] = 1'b1;
        wait_lvl(1, 1'b1, "press6_valid");
        chk("press6_code", 32'(bus.code), 32'h06);
        chk("press6_col",  32'(bus.col),  32'hB);
        chk("press6_busy", 32'(bus.busy), 32'd1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("held_col",   32'(bus.col),   32'hB);
        chk("held_valid", 32'(bus.valid), 32'd1);
        @(posedge clk); #1;
        bus.ready = 1'b1;
        keys[6] = 1'b0;
        wait_lvl(0, 1'b0, "rel6_busy_fall");
        repeat (3) @(posedge clk); #1;
        drain("press6");

        // Bouncing press: closed/open every 3 clocks, then stable closed.
        push_exp(5'h06);
        p0 = n_pop;
        for (int i = 0; i < 7; i++) begin
            keys[6] = ~keys[6];
            repeat (3) @(posedge clk); #1;
        end
        chk("bounce_no_event", 32'(n_pop), 32'(p0));
        begin
            bit ok = 1'b0;
            for (int i = 0; i < 200 && !ok; i++) begin
                @(negedge clk);
                ok = (n_pop > p0);
            end
            chk("bounce_event_seen", 32'(ok), 32'd1);
        end
        repeat (6) @(posedge clk); #1;
        chk("bounce_one_event", 32'(n_pop - p0), 32'd1);
        keys[6] = 1'b0;
        wait_lvl(0, 1'b0, "bounce_busy_fall");
        repeat (3) @(posedge clk); #1;
        drain("bounce");

        // Five keys with the consumer stalled: four queue, the rest drop.
        bus.ready = 1'b0;
        o0 = n_ovf;
        keyl = '{0, 5, 10, 15, 3};
        nev = 0;
        for (int i = 0; i < 5; i++) begin
            evl[nev] = 5'(keyl[i]); nev++;
`ifdef KEYPAD_RELEASE_EVT_EN
            evl[nev] = 5'(keyl[i]) | 5'h10; nev++;
`endif
        end
        for (int i = 0; i < 4; i++) sb.push_back(evl[i]);
        for (int i = 0; i < 5; i++) press_release(16'(1) << keyl[i], "fill");
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("overflow_count", 32'(n_ovf - o0), 32'(nev - 4));
        chk("full_valid",     32'(bus.valid),  32'd1);
        chk("full_head",      32'(bus.code),   32'(evl[0]));
        @(posedge clk); #1;
        bus.ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("drained_valid", 32'(bus.valid), 32'd0);
        drain("fifo_order");

        // Rows 0 and 3 on column 1 together: lowest row wins, one event.
        push_exp(5'h01);
        press_release(16'h2002, "multi");
        repeat (3) @(posedge clk); #1;
        drain("multi");

        // Reset during release debounce with an event still queued.
        bus.ready = 1'b0;
        keys[6] = 1'b1;
        wait_lvl(1, 1'b1, "pre_rst_valid");
        chk("pre_rst_code", 32'(bus.code), 32'h06);
        repeat (4) @(posedge clk); #1;
        keys[6] = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_busy", 32'(bus.busy), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(bus.valid), 32'd0);
        chk("async_rst_col",   32'(bus.col),   32'hE);
        chk("async_rst_busy",  32'(bus.busy),  32'd0);
        chk("async_rst_code",  32'(bus.code),  32'd0);
        sb.delete();
        p0 = n_pop;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.ready = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("post_rst_no_event", 32'(n_pop), 32'(p0));
        chk("post_rst_valid",    32'(bus.valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
